// File: rtl/calc_sched_pkg.sv
// calc_sched_pkg
//   Shared types and constants for the calc_sched round-robin scheduler.
//   - state_e : scheduler FSM states
//   - tag_t   : in-flight operation tag {valid, requester id}
//   - CNT_W   : width of the accepted-request counter
package calc_sched_pkg;

  localparam int CNT_W = 16;

  // Id field is sized for the largest supported requester count (8), so one
  // tag type serves every NREQ in the legal 2..8 range.
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/calc_rr_arb.sv
// calc_rr_arb
//   Purely combinational round-robin arbiter. Grants the lowest eligible
//   index that is >= ptr_i; if none, wraps to the lowest eligible index.
//   Ports:
//     eligible_i : NREQ  request mask already qualified by the caller
//     ptr_i      : PTR_W round-robin start position (register lives in parent)
//     grant_o    : NREQ  one-hot grant (all zero when nothing eligible)
//     idx_o      : PTR_W encoded index of the granted requester
//     valid_o    : 1     a grant was made
module calc_rr_arb #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  eligible_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic             hit_hi;
  logic             hit_lo;
  logic [PTR_W-1:0] idx_hi;
  logic [PTR_W-1:0] idx_lo;

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        hit_lo = 1'b1;
        idx_lo = PTR_W'(i);
        if (PTR_W'(i) >= ptr_i) begin
          hit_hi = 1'b1;
          idx_hi = PTR_W'(i);
        end
      end
    end
  end

  assign valid_o = hit_lo;
  assign idx_o   = hit_hi ? idx_hi : idx_lo;
  assign grant_o = hit_lo ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/calc_sched.sv
// calc_sched
//   Round-robin scheduler sharing one external registered add/subtract unit
//   (CALC) between NREQ requesters. Arbitrates operand requests, drives the
//   CALC operands, tracks in-flight operations by tag across the CALC latency
//   and returns each result to its originating requester.
//   Ports:
//     clk, reset          : clock, asynchronous active-low reset
//     cfg_en, cfg_mask    : scheduler enable, per-requester enable
//     req_valid/req_ready : per-requester handshake (ready is one-hot)
//     req_i0, req_i1      : packed operands, requester k at [k*WD +: WD]
//     calc_I0, calc_I1    : registered operands to the shared CALC
//     calc_O              : CALC result, valid LAT cycles after operands
//     rsp_valid, rsp_data : one-hot result strobe and result data
//     busy                : not IDLE or operations still in flight
//     issue_cnt           : accepted request count (wraps)
import calc_sched_pkg::*;

module calc_sched #(
  parameter int NREQ = 4,
  parameter int WD   = 16,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_en,
  input  logic [NREQ-1:0]      cfg_mask,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WD-1:0]   req_i0,
  input  logic [NREQ*WD-1:0]   req_i1,
  output logic [NREQ-1:0]      req_ready,
  output logic [WD-1:0]        calc_I0,
  output logic [WD-1:0]        calc_I1,
  input  logic [WD-1:0]        calc_O,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WD-1:0]        rsp_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     issue_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WD-1:0]     calc_i0_q, calc_i1_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [WD-1:0]     rsp_data_q;

  // Stage 0 lines up with calc_I0/I1, stage LAT with calc_O.
  tag_t              tag_q [LAT+1];
  tag_t              tag_in;
  logic [LAT:0]      tag_vld;
  logic              in_flight;

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              xfer;

  // Grants exist only in RUN; mask changes act in the same cycle.
  assign eligible = (state_q == RUN) ? (req_valid & cfg_mask) : '0;

  calc_rr_arb #(
    .NREQ (NREQ),
    .PTR_W(PTR_W)
  ) u_arb (
    .eligible_i(eligible),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .idx_o     (grant_idx),
    .valid_o   (xfer)
  );

  // A grant is only ever given to a valid requester, so grant == transfer.
  assign req_ready = grant;
  assign tag_in    = '{vld: xfer, id: ID_W'(grant_idx)};

  genvar gi;
  generate
    for (gi = 0; gi <= LAT; gi++) begin : g_vld
      assign tag_vld[gi] = tag_q[gi].vld;
    end
  endgenerate
  assign in_flight = |tag_vld;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE:    if (cfg_en) state_d = RUN;
      RUN:     if (!cfg_en) state_d = DRAIN;
      DRAIN: begin
        if (cfg_en)          state_d = RUN;
        else if (!in_flight) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      calc_i0_q   <= '0;
      calc_i1_q   <= '0;
      issue_cnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        calc_i0_q   <= req_i0[grant_idx*WD +: WD];
        calc_i1_q   <= req_i1[grant_idx*WD +: WD];
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      // Completion is never masked: whatever reaches the end responds.
      if (tag_q[LAT].vld) begin
        rsp_valid_q <= NREQ'(1) << tag_q[LAT].id;
        rsp_data_q  <= calc_O;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign calc_I0   = calc_i0_q;
  assign calc_I1   = calc_i1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign issue_cnt = issue_cnt_q;
  assign busy      = (state_q != IDLE) || in_flight;

endmodule

// File: tb/tb_calc_sched.sv
module tb_calc_sched;

  localparam int NREQ = 4;
  localparam int WD   = 16;
  localparam int LAT  = 1;

  logic                clk;
  logic                reset;
  logic                cfg_en;
  logic [NREQ-1:0]     cfg_mask;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*WD-1:0]  req_i0;
  logic [NREQ*WD-1:0]  req_i1;
  logic [NREQ-1:0]     req_ready;
  logic [WD-1:0]       calc_I0;
  logic [WD-1:0]       calc_I1;
  logic [WD-1:0]       calc_O;
  logic [NREQ-1:0]     rsp_valid;
  logic [WD-1:0]       rsp_data;
  logic                busy;
  logic [15:0]         issue_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected grants of the last three cycles; index 2 is due as a response now.
  logic [NREQ-1:0] hist [3];

  calc_sched #(.NREQ(NREQ), .WD(WD), .LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_mask (cfg_mask),
    .req_valid(req_valid),
    .req_i0   (req_i0),
    .req_i1   (req_i1),
    .req_ready(req_ready),
    .calc_I0  (calc_I0),
    .calc_I1  (calc_I1),
    .calc_O   (calc_O),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .issue_cnt(issue_cnt)
  );

  // Behavioural CALC: registered subtract, LAT cycles deep.
  logic [WD-1:0] calc_pipe [LAT];
  always @(posedge clk) begin
    calc_pipe[0] <= calc_I0 - calc_I1;
    for (int i = 1; i < LAT; i++) calc_pipe[i] <= calc_pipe[i-1];
  end
  assign calc_O = calc_pipe[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed I0 - I1 per requester (requester 3 wraps below zero).
  function automatic logic [WD-1:0] exp_diff(input logic [NREQ-1:0] oh);
    case (oh)
      4'b0001: return 16'h0002;  // 0x0005 - 0x0003
      4'b0010: return 16'h000F;  // 0x0010 - 0x0001
      4'b0100: return 16'h00FE;  // 0x0100 - 0x0002
      4'b1000: return 16'hFFFE;  // 0x0001 - 0x0003
      default: return 16'hxxxx;
    endcase
  endfunction

  // One clock cycle: starts and ends just after a rising edge.
  task automatic cyc(input logic en, input logic [NREQ-1:0] mask, input logic [NREQ-1:0] vld,
                     input logic [NREQ-1:0] exp_rdy, input logic exp_busy);
    cfg_en    = en;
    cfg_mask  = mask;
    req_valid = vld;
    #1;
    expect_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    expect_eq("rsp_valid", 32'(rsp_valid), 32'(hist[2]));
    if (hist[2] != '0) expect_eq("rsp_data", 32'(rsp_data), 32'(exp_diff(hist[2])));
    expect_eq("busy", 32'(busy), 32'(exp_busy));
    $display("t=%0t en=%b mask=%b vld=%b ready=%b rsp=%b data=%h busy=%b cnt=%0d",
             $time, en, mask, vld, req_ready, rsp_valid, rsp_data, busy, issue_cnt);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = exp_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    expect_eq("rst_req_ready", 32'(req_ready), 32'h0);
    expect_eq("rst_calc_I0",   32'(calc_I0),   32'h0);
    expect_eq("rst_calc_I1",   32'(calc_I1),   32'h0);
    expect_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    expect_eq("rst_rsp_data",  32'(rsp_data),  32'h0);
    expect_eq("rst_busy",      32'(busy),      32'h0);
    expect_eq("rst_issue_cnt", 32'(issue_cnt), 32'h0);
    for (int i = 0; i < 3; i++) hist[i] = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_en    = 1'b0;
    cfg_mask  = 4'hF;
    req_valid = '0;
    req_i0    = {16'h0001, 16'h0100, 16'h0010, 16'h0005};
    req_i1    = {16'h0003, 16'h0002, 16'h0001, 16'h0003};
    for (int i = 0; i < 3; i++) hist[i] = '0;
    #2;

    // Single transfer from requester 0: 5 - 3 = 2, three cycles later.
    do_reset();
    cyc(1, 4'hF, 4'b0001, 4'b0000, 0);   // IDLE: no grant yet
    cyc(1, 4'hF, 4'b0001, 4'b0001, 1);
    expect_eq("calc_I0", 32'(calc_I0), 32'h0005);
    expect_eq("calc_I1", 32'(calc_I1), 32'h0003);
    expect_eq("issue_cnt_1", 32'(issue_cnt), 32'd1);
    cyc(1, 4'hF, 4'b0000, 4'b0000, 1);
    cyc(1, 4'hF, 4'b0000, 4'b0000, 1);
    cyc(1, 4'hF, 4'b0000, 4'b0000, 1);   // response due here
    expect_eq("rsp_data_hold", 32'(rsp_data), 32'h0002);

    // All requesters valid, full mask: 0,1,2,3,0,1,2,3 back to back.
    do_reset();
    cyc(1, 4'hF, 4'hF, 4'b0000, 0);
    for (int r = 0; r < 2; r++) begin
      cyc(1, 4'hF, 4'hF, 4'b0001, 1);
      cyc(1, 4'hF, 4'hF, 4'b0010, 1);
      cyc(1, 4'hF, 4'hF, 4'b0100, 1);
      cyc(1, 4'hF, 4'hF, 4'b1000, 1);
    end
    for (int i = 0; i < 3; i++) cyc(1, 4'hF, 4'h0, 4'b0000, 1);
    expect_eq("issue_cnt_8", 32'(issue_cnt), 32'd8);

    // Mask 1010: only 1 and 3, alternating.
    for (int r = 0; r < 3; r++) begin
      cyc(1, 4'b1010, 4'hF, 4'b0010, 1);
      cyc(1, 4'b1010, 4'hF, 4'b1000, 1);
    end
    for (int i = 0; i < 3; i++) cyc(1, 4'hF, 4'h0, 4'b0000, 1);
    expect_eq("issue_cnt_14", 32'(issue_cnt), 32'd14);

    // Pointer wrap: grant 2 -> pointer 3; eligible 0011 wraps to 0, then 1.
    cyc(1, 4'hF, 4'b0100, 4'b0100, 1);
    cyc(1, 4'hF, 4'b0011, 4'b0001, 1);
    cyc(1, 4'hF, 4'b0011, 4'b0010, 1);
    for (int i = 0; i < 3; i++) cyc(1, 4'hF, 4'h0, 4'b0000, 1);

    // Drain: grant still allowed in the cycle cfg_en falls, none after.
    do_reset();
    cyc(1, 4'hF, 4'hF, 4'b0000, 0);
    cyc(1, 4'hF, 4'hF, 4'b0001, 1);
    cyc(1, 4'hF, 4'hF, 4'b0010, 1);
    cyc(0, 4'hF, 4'hF, 4'b0100, 1);
    cyc(0, 4'hF, 4'hF, 4'b0000, 1);
    cyc(0, 4'hF, 4'hF, 4'b0000, 1);
    cyc(0, 4'hF, 4'hF, 4'b0000, 1);      // last response, still DRAIN
    cyc(0, 4'hF, 4'hF, 4'b0000, 0);      // IDLE
    expect_eq("issue_cnt_drain", 32'(issue_cnt), 32'd3);
    cyc(1, 4'hF, 4'hF, 4'b0000, 0);      // IDLE -> RUN takes a cycle
    cyc(1, 4'hF, 4'hF, 4'b1000, 1);      // pointer was 3

    // Two issues, then reset mid-flight: nothing may come out afterwards.
    cyc(1, 4'hF, 4'hF, 4'b0001, 1);
    do_reset();
    cyc(1, 4'hF, 4'h0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) cyc(1, 4'hF, 4'h0, 4'b0000, 1);
    expect_eq("issue_cnt_after_rst", 32'(issue_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
